// File: rtl/service_strip.sv
// ---------------------------------------------------------------------------
// service_strip
//
// Removes the framing around a descrambled serial PSDU stream. The leading
// SERVICE bits are discarded. The PSDU bits are packed LSB-first into bytes.
// The tail bits and pad bits that follow are discarded as well.
//
// Ports
//   Clk         sole clock, rising edge
//   Reset       asynchronous, active-low reset
//   x           descrambled serial bit
//   x_valid     x is meaningful this cycle
//   start       one-cycle frame-start pulse (latches len_bytes / num_pads)
//   len_bytes   PSDU length in bytes (0..4095)
//   num_pads    pad bits following the tail (0..287)
//   data_byte   last assembled PSDU byte, held until the next one completes
//   byte_valid  one-cycle pulse when data_byte has just been updated
//   busy        frame in progress
//   done        one-cycle pulse at frame end
//   err         one-cycle pulse when start arrives mid-frame (abort/restart)
// ---------------------------------------------------------------------------
module service_strip #(
    parameter int SERVICE_BITS = 16,
    parameter int TAIL_BITS    = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        x,
    input  logic        x_valid,
    input  logic        start,
    input  logic [11:0] len_bytes,
    input  logic [8:0]  num_pads,
    output logic [7:0]  data_byte,
    output logic        byte_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, SERVICE, DATA, TAILPAD, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] len_q;
    logic [8:0]  pads_q;
    logic [14:0] cnt;
    logic [7:0]  shift_q;

    logic [9:0]  tailpad_total;
    logic [14:0] service_last;
    logic [14:0] data_last;
    logic [14:0] tailpad_last;
    logic        in_frame;

    // The counter is compared against (length - 1) of each phase, so a phase
    // ends on the same edge that samples its final valid bit.
    assign tailpad_total = 10'(TAIL_BITS) + {1'b0, pads_q};
    assign service_last  = 15'(SERVICE_BITS - 1);
    assign data_last     = {len_q, 3'b000} - 15'd1;
    assign tailpad_last  = {5'b00000, tailpad_total} - 15'd1;
    assign in_frame      = (state == SERVICE) || (state == DATA) || (state == TAILPAD);

    // Every output is derived from registers only.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start pulse always wins over bit processing. A start in any non-idle
    // state restarts the frame at SERVICE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = SERVICE;
            end
            SERVICE: begin
                if (start) begin
                    state_next = SERVICE;
                end else if (x_valid && cnt == service_last) begin
                    if (len_q != 12'd0)              state_next = DATA;
                    else if (tailpad_total != 10'd0) state_next = TAILPAD;
                    else                             state_next = DONE;
                end
            end
            DATA: begin
                if (start) begin
                    state_next = SERVICE;
                end else if (x_valid && cnt == data_last) begin
                    state_next = (tailpad_total != 10'd0) ? TAILPAD : DONE;
                end
            end
            TAILPAD: begin
                if (start) begin
                    state_next = SERVICE;
                end else if (x_valid && cnt == tailpad_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = start ? SERVICE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One counter serves every phase. It restarts whenever the phase changes
    // or a new frame begins, and it only advances on valid bits inside a frame.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (start || state_next != state) begin
            cnt <= '0;
        end else if (x_valid && in_frame) begin
            cnt <= cnt + 15'd1;
        end
    end

    // Byte assembly. Bits enter at the top and shift right, so the first bit
    // of a byte ends up in bit 0. A restart discards any partial byte.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            len_q      <= '0;
            pads_q     <= '0;
            shift_q    <= '0;
            data_byte  <= 8'h00;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            if (start) begin
                err     <= in_frame;
                len_q   <= len_bytes;
                pads_q  <= num_pads;
                shift_q <= '0;
            end else if (state == DATA && x_valid) begin
                shift_q <= {x, shift_q[7:1]};
                if (cnt[2:0] == 3'b111) begin
                    data_byte  <= {x, shift_q[7:1]};
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_service_strip.sv
// ---------------------------------------------------------------------------
// tb_service_strip
//
// Directed frames drive service_strip. A bit-count model predicts every
// output on every cycle. Scenario-level literal expectations (byte values,
// pulse counts, done timing) check the model itself.
// ---------------------------------------------------------------------------
module tb_service_strip;

    localparam int S = 16;
    localparam int T = 6;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        x = 1'b0;
    logic        x_valid = 1'b0;
    logic        start = 1'b0;
    logic [11:0] len_bytes = '0;
    logic [8:0]  num_pads = '0;
    logic [7:0]  data_byte;
    logic        byte_valid;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    service_strip #(.SERVICE_BITS(S), .TAIL_BITS(T)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .x          (x),
        .x_valid    (x_valid),
        .start      (start),
        .len_bytes  (len_bytes),
        .num_pads   (num_pads),
        .data_byte  (data_byte),
        .byte_valid (byte_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    // Frame model: counts valid bits since start and derives each phase from
    // plain thresholds (S, S + 8L, S + 8L + T + P).
    bit       m_on;
    int       m_nb;
    int       m_len;
    int       m_pads;
    logic [7:0] m_acc;
    logic       m_bv;
    logic [7:0] m_byte;
    logic       m_busy;
    logic       m_done;
    logic       m_err;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_on = 0; m_nb = 0; m_len = 0; m_pads = 0; m_acc = '0;
            m_bv = 0; m_byte = 8'h00; m_busy = 0; m_done = 0; m_err = 0;
        end else begin
            logic prev_done;
            prev_done = m_done;
            m_done = 0;
            m_err  = 0;
            m_bv   = 0;
            if (start) begin
                m_err  = m_busy && !prev_done;
                m_on   = 1;
                m_busy = 1;
                m_nb   = 0;
                m_len  = int'(len_bytes);
                m_pads = int'(num_pads);
            end else begin
                if (prev_done) m_busy = 0;
                if (m_on && x_valid) begin
                    m_nb++;
                    if (m_nb > S && m_nb <= S + 8 * m_len) begin
                        int k;
                        k = m_nb - S - 1;
                        m_acc[k % 8] = x;
                        if (k % 8 == 7) begin
                            m_bv   = 1;
                            m_byte = m_acc;
                        end
                    end
                    if (m_nb == S + 8 * m_len + T + m_pads) begin
                        m_on   = 0;
                        m_done = 1;
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge Clk) begin
        if (check_en) begin
            check_output("cyc_byte_valid", 32'(byte_valid), 32'(m_bv));
            check_output("cyc_data_byte",  32'(data_byte),  32'(m_byte));
            check_output("cyc_busy",       32'(busy),       32'(m_busy));
            check_output("cyc_done",       32'(done),       32'(m_done));
            check_output("cyc_err",        32'(err),        32'(m_err));
        end
    end

    // Monitor collecting emitted bytes and pulse counts for literal checks.
    logic [7:0] got[$];
    int done_count = 0;
    int err_count = 0;

    always @(negedge Clk) begin
        if (byte_valid) got.push_back(data_byte);
        if (done) done_count++;
        if (err) err_count++;
    end

    task automatic drive_bit(input logic b, input logic v);
        @(negedge Clk);
        start   = 1'b0;
        x       = b;
        x_valid = v;
    endtask

    task automatic apply_stimulus(input int l, input int p);
        @(negedge Clk);
        start     = 1'b1;
        len_bytes = 12'(l);
        num_pads  = 9'(p);
        x         = 1'b1;
        x_valid   = 1'b1;
    endtask

    task automatic send_bits(input logic b, input int n);
        for (int i = 0; i < n; i++) drive_bit(b, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b1);
    endtask

    // Valid bit followed by an invalid cycle that carries the opposite value.
    task automatic send_byte_toggled(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i], 1'b1);
            drive_bit(~b[i], 1'b0);
        end
    endtask

    task automatic send_bits_toggled(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            drive_bit(b, 1'b1);
            drive_bit(~b, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0);
    endtask

    // The negedge after the last bit is driven is the cycle after it was
    // sampled, which is when done must be high.
    task automatic expect_done_now(input string name);
        @(negedge Clk);
        start   = 1'b0;
        x_valid = 1'b0;
        check_output(name, 32'(done), 32'd1);
    endtask

    task automatic clear_scoreboard();
        got.delete();
        done_count = 0;
        err_count  = 0;
    endtask

    initial begin
        $display("[TB] starting service_strip bench");
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        check_en = 1'b1;
        @(negedge Clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_data_byte", 32'(data_byte), 32'd0);
        Reset = 1'b1;
        idle(2);
        clear_scoreboard();

        // Frame 1: one byte, no pads.
        apply_stimulus(1, 0);
        send_bits(1'b0, 16);
        drive_bit(1, 1); drive_bit(0, 1); drive_bit(1, 1); drive_bit(1, 1);
        drive_bit(0, 1); drive_bit(0, 1); drive_bit(1, 1); drive_bit(0, 1);
        send_bits(1'b0, 5);
        @(negedge Clk);
        x = 1'b0; x_valid = 1'b1;
        check_output("f1_no_early_done", 32'(done), 32'd0);
        expect_done_now("f1_done_timing");
        idle(3);
        check_output("f1_nbytes", 32'(got.size()), 32'd1);
        check_output("f1_byte0", 32'(got[0]), 32'h4D);
        check_output("f1_done_count", 32'(done_count), 32'd1);
        check_output("f1_err_count", 32'(err_count), 32'd0);
        clear_scoreboard();

        // Frame 2: three bytes, five pads, x_valid toggling every cycle.
        apply_stimulus(3, 5);
        send_bits_toggled(1'b0, 16);
        send_byte_toggled(8'hA5);
        send_byte_toggled(8'h3C);
        send_byte_toggled(8'hFF);
        send_bits_toggled(1'b0, 10);
        drive_bit(1'b0, 1'b1);
        expect_done_now("f2_done_timing");
        idle(3);
        check_output("f2_nbytes", 32'(got.size()), 32'd3);
        check_output("f2_byte0", 32'(got[0]), 32'hA5);
        check_output("f2_byte1", 32'(got[1]), 32'h3C);
        check_output("f2_byte2", 32'(got[2]), 32'hFF);
        check_output("f2_done_count", 32'(done_count), 32'd1);
        clear_scoreboard();

        // Frame 3: zero length, zero pads -> 22 bits then done.
        apply_stimulus(0, 0);
        send_bits(1'b1, 21);
        check_output("f3_busy_before_last", 32'(busy), 32'd1);
        drive_bit(1'b1, 1'b1);
        expect_done_now("f3_done_timing");
        idle(3);
        check_output("f3_nbytes", 32'(got.size()), 32'd0);
        check_output("f3_done_count", 32'(done_count), 32'd1);
        clear_scoreboard();

        // Frame 4: restart during DATA after four data bits.
        apply_stimulus(2, 0);
        send_bits(1'b0, 16);
        send_bits(1'b1, 4);
        apply_stimulus(1, 0);
        send_bits(1'b1, 16);
        send_byte(8'h5A);
        send_bits(1'b0, 6);
        expect_done_now("f4_done_timing");
        idle(3);
        check_output("f4_err_count", 32'(err_count), 32'd1);
        check_output("f4_nbytes", 32'(got.size()), 32'd1);
        check_output("f4_byte0", 32'(got[0]), 32'h5A);
        check_output("f4_done_count", 32'(done_count), 32'd1);
        clear_scoreboard();

        // Frame 5: reset pulsed mid-DATA, then a clean two-byte frame.
        apply_stimulus(2, 0);
        send_bits(1'b0, 16);
        send_bits(1'b1, 5);
        @(negedge Clk);
        x_valid = 1'b1;
        #2 Reset = 1'b0;
        #1;
        check_output("f5_rst_busy", 32'(busy), 32'd0);
        check_output("f5_rst_byte_valid", 32'(byte_valid), 32'd0);
        check_output("f5_rst_data_byte", 32'(data_byte), 32'd0);
        check_output("f5_rst_done", 32'(done), 32'd0);
        check_output("f5_rst_err", 32'(err), 32'd0);
        idle(2);
        Reset = 1'b1;
        idle(2);
        apply_stimulus(2, 2);
        send_bits(1'b0, 16);
        send_byte(8'hC3);
        send_byte(8'h81);
        send_bits(1'b1, 8);
        expect_done_now("f5_done_timing");
        idle(3);
        check_output("f5_nbytes", 32'(got.size()), 32'd2);
        check_output("f5_byte0", 32'(got[0]), 32'hC3);
        check_output("f5_byte1", 32'(got[1]), 32'h81);
        check_output("f5_done_count", 32'(done_count), 32'd1);
        check_output("f5_err_count", 32'(err_count), 32'd0);
        clear_scoreboard();

        // Frame 6: back-to-back frames, second start issued in the DONE cycle.
        apply_stimulus(1, 0);
        send_bits(1'b0, 16);
        send_byte(8'h96);
        send_bits(1'b0, 6);
        @(negedge Clk);
        start     = 1'b1;
        len_bytes = 12'd1;
        num_pads  = 9'd1;
        x_valid   = 1'b0;
        check_output("f6_done_in_done_cycle", 32'(done), 32'd1);
        send_bits(1'b0, 16);
        send_byte(8'h17);
        send_bits(1'b0, 7);
        expect_done_now("f6_second_done_timing");
        idle(3);
        check_output("f6_err_count", 32'(err_count), 32'd0);
        check_output("f6_done_count", 32'(done_count), 32'd2);
        check_output("f6_nbytes", 32'(got.size()), 32'd2);
        check_output("f6_byte0", 32'(got[0]), 32'h96);
        check_output("f6_byte1", 32'(got[1]), 32'h17);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
